// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM encodings,
// iterative-unit modes and the debug view of the control state.
package exec_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int OP_W_DEF       = 4;

    localparam logic [OP_W_DEF-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W_DEF-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W_DEF-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W_DEF-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W_DEF-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W_DEF-1:0] OP_SLT  = 4'd5;
    localparam logic [OP_W_DEF-1:0] OP_SLTU = 4'd6;
    localparam logic [OP_W_DEF-1:0] OP_SLL  = 4'd7;
    localparam logic [OP_W_DEF-1:0] OP_SRL  = 4'd8;
    localparam logic [OP_W_DEF-1:0] OP_SRA  = 4'd9;
    localparam logic [OP_W_DEF-1:0] OP_MUL  = 4'd10;
    localparam logic [OP_W_DEF-1:0] OP_DIVU = 4'd11;
    localparam logic [OP_W_DEF-1:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_mode_t;

    // Observable control state for checkers and debug.
    typedef struct packed {
        state_t state;
        logic   md_busy;
    } exec_dbg_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiply / unsigned divide. One shift-add (MUL) or restoring
// subtract (DIVU/REMU) step per clock, DATA_W steps per op. The accumulator
// doubles as product (MUL) and partial remainder (DIVU/REMU).
module iter_muldiv
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              abort,
    input  logic              start,
    input  md_mode_t          mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] acc_q, q_q, m_q;
    logic [DATA_W-1:0] acc_d, q_d, m_d;
    logic [DATA_W:0]   rem_shift, rem_diff;
    md_mode_t          mode_q;
    logic [CW-1:0]     count_q;
    logic              busy_q;

    // One iteration step; result is the post-step value so the caller can
    // capture it on the same edge as the final step.
    always_comb begin
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        rem_shift = {acc_q, q_q[DATA_W-1]};
        rem_diff  = rem_shift - {1'b0, m_q};
        if (mode_q == MD_MUL) begin
            if (q_q[0]) begin
                acc_d = acc_q + m_q;
            end
            m_d = m_q << 1;
            q_d = q_q >> 1;
        end else if (rem_shift >= {1'b0, m_q}) begin
            // Divisor 0 always "fits": quotient all ones, remainder = dividend.
            acc_d = rem_diff[DATA_W-1:0];
            q_d   = {q_q[DATA_W-2:0], 1'b1};
        end else begin
            acc_d = rem_shift[DATA_W-1:0];
            q_d   = {q_q[DATA_W-2:0], 1'b0};
        end
    end

    assign busy   = busy_q;
    assign done   = busy_q && (count_q == CW'(DATA_W - 1));
    assign result = (mode_q == MD_DIVU) ? q_d : acc_d;

    // Operand load on start, step while busy, abort clears everything.
    always_ff @(posedge clk) begin
        if (abort) begin
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            mode_q  <= MD_MUL;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            acc_q   <= '0;
            m_q     <= (mode == MD_MUL) ? a : b;
            q_q     <= (mode == MD_MUL) ? b : a;
            mode_q  <= mode;
            count_q <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_d;
            q_q   <= q_d;
            m_q   <= m_d;
            if (done) begin
                busy_q  <= 1'b0;
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: handshake FSM, single-cycle ALU, iterative MUL/DIVU/REMU
// and a registered write-back bundle.
//
// Handshake: an op transfers on an edge where in_valid && in_ready && !flush;
// a result transfers on an edge where out_valid && out_ready. While out_valid
// is high and out_ready is low every output field is held unchanged.
module execute_unit
    import exec_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int OP_W       = OP_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       op,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    input  logic                  reg_write_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     result,
    output logic                  zero,
    output logic                  illegal_op,
    output logic [REG_ADDR_W-1:0] dest_reg_out,
    output logic                  reg_write_out,
    output exec_dbg_t             dbg
);

    localparam int SHW = $clog2(DATA_W);

    state_t                state_q, state_d;
    logic                  accept, is_iter, illegal;
    logic [DATA_W-1:0]     alu_res;
    logic [SHW-1:0]        shamt;
    md_mode_t              md_mode;
    logic                  md_start, md_busy, md_done;
    logic [DATA_W-1:0]     md_result;
    logic [DATA_W-1:0]     result_q;
    logic                  zero_q, illegal_q, regwr_q;
    logic [REG_ADDR_W-1:0] dest_q;

    assign is_iter = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    assign illegal = (op > OP_REMU);
    assign accept  = in_valid && in_ready && !flush;
    assign shamt   = operand_b[SHW-1:0];

    // Single-cycle ALU; iterative and illegal opcodes yield 0 here.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = operand_a + operand_b;
            OP_SUB:  alu_res = operand_a - operand_b;
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, operand_a < operand_b};
            OP_SLL:  alu_res = operand_a << shamt;
            OP_SRL:  alu_res = operand_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(operand_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Select the iterative unit's mode from the opcode.
    always_comb begin
        md_mode = MD_REMU;
        if (op == OP_MUL) begin
            md_mode = MD_MUL;
        end else if (op == OP_DIVU) begin
            md_mode = MD_DIVU;
        end
    end

    iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk    (clk),
        .abort  (rst | flush),
        .start  (md_start),
        .mode   (md_mode),
        .a      (operand_a),
        .b      (operand_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything except reset.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = is_iter ? ST_BUSY : ST_DONE;
                ST_BUSY: if (md_done) state_d = ST_DONE;
                ST_DONE: if (out_ready) state_d = accept ? (is_iter ? ST_BUSY : ST_DONE) : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
        md_start  = accept && is_iter;
    end

    // Write-back bundle: loaded on single-cycle accept or on the final iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            dest_q    <= '0;
            regwr_q   <= 1'b0;
        end else if (accept && !is_iter) begin
            result_q  <= alu_res;
            zero_q    <= (alu_res == '0);
            illegal_q <= illegal;
            dest_q    <= dest_reg;
            regwr_q   <= reg_write_in && !illegal;
        end else if (accept) begin
            illegal_q <= 1'b0;
            dest_q    <= dest_reg;
            regwr_q   <= reg_write_in;
        end else if (md_done && !flush && (state_q == ST_BUSY)) begin
            result_q  <= md_result;
            zero_q    <= (md_result == '0);
        end
    end

    assign result        = result_q;
    assign zero          = zero_q;
    assign illegal_op    = illegal_q;
    assign dest_reg_out  = dest_q;
    assign reg_write_out = regwr_q;
    assign dbg.state     = state_q;
    assign dbg.md_busy   = md_busy;

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed scenarios plus a randomized
// run compared against an arithmetic reference model.
module tb_execute_unit;
  import exec_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] op = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [4:0] dest_reg = '0;
  logic reg_write_in = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] result;
  logic zero;
  logic illegal_op;
  logic [4:0] dest_reg_out;
  logic reg_write_out;
  exec_dbg_t dbg;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [4:0] exp_dest_q[$];
  logic exp_rw_q[$];
  logic exp_ill_q[$];

  execute_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b),
    .dest_reg(dest_reg), .reg_write_in(reg_write_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal_op(illegal_op),
    .dest_reg_out(dest_reg_out), .reg_write_out(reg_write_out),
    .dbg(dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_result(input logic [3:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    int unsigned sh;
    sh = b % W;
    case (o)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6: return (a < b) ? 1 : 0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return $unsigned($signed(a) >>> sh);
      4'd10: begin prod = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return prod[W-1:0]; end
      4'd11: return (b == 0) ? {W{1'b1}} : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] d, input logic rw);
    int waited;
    waited = 0;
    op = o; operand_a = a; operand_b = b; dest_reg = d; reg_write_in = rw; in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_in_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int limit, output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", zero); end
    checks++; if (illegal_op !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal_op); end
    checks++; if (dest_reg_out !== '0) begin failures++; $display("FAIL reset_dest got=%h exp=0", dest_reg_out); end
    checks++; if (reg_write_out !== 1'b0) begin failures++; $display("FAIL reset_regwr got=%b exp=0", reg_write_out); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_latency out_valid got=%b exp=1", out_valid); end
    checks++; if (result !== 32'h8000_0000) begin failures++; $display("FAIL add_result got=%h exp=80000000", result); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", zero); end
    checks++; if (dest_reg_out !== 5'd3) begin failures++; $display("FAIL add_dest got=%0d exp=3", dest_reg_out); end
    checks++; if (reg_write_out !== 1'b1) begin failures++; $display("FAIL add_regwr got=%b exp=1", reg_write_out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_consumed out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(4'd1, 32'd5, 32'd5, 5'd0, 1'b1);
    checks++; if (result !== '0 || zero !== 1'b1) begin failures++; $display("FAIL b2b_sub got=%h zero=%b exp=0 zero=1", result, zero); end
    checks++; if (dest_reg_out !== 5'd0) begin failures++; $display("FAIL b2b_dest0 got=%0d exp=0", dest_reg_out); end
    op = 4'd5; operand_a = 32'hFFFF_FFFF; operand_b = 32'd1; dest_reg = 5'd4; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd1 || zero !== 1'b0) begin
      failures++; $display("FAIL b2b_slt valid=%b got=%h zero=%b exp=1 zero=0", out_valid, result, zero);
    end
    tick();
  endtask

  task automatic test_mul();
    int cycles;
    int busy_ready_seen;
    out_ready = 1'b1;
    busy_ready_seen = 0;
    send(4'd10, 32'h0001_0000, 32'h0001_0000, 5'd8, 1'b1);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 60) begin
      if (in_ready !== 1'b0) busy_ready_seen++;
      tick();
      cycles++;
    end
    checks++; if (cycles != W) begin failures++; $display("FAIL mul_latency got=%0d exp=%0d", cycles, W); end
    checks++; if (busy_ready_seen != 0) begin failures++; $display("FAIL mul_busy_in_ready got=%0d cycles high exp=0", busy_ready_seen); end
    checks++; if (result !== '0 || zero !== 1'b1) begin failures++; $display("FAIL mul_result got=%h zero=%b exp=0 zero=1", result, zero); end
    tick();
  endtask

  task automatic test_div();
    logic [3:0] ops[4];
    logic [W-1:0] as[4];
    logic [W-1:0] bs[4];
    logic [W-1:0] exps[4];
    int cycles;
    ops = '{4'd11, 4'd12, 4'd11, 4'd12};
    as = '{32'd100, 32'd100, 32'd9, 32'd9};
    bs = '{32'd7, 32'd7, 32'd0, 32'd0};
    exps = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], as[i], bs[i], 5'd5, 1'b1);
      wait_out(60, cycles);
      checks++; if (out_valid !== 1'b1 || result !== exps[i]) begin
        failures++; $display("FAIL div_case%0d valid=%b got=%h exp=%h", i, out_valid, result, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] held;
    int bad;
    out_ready = 1'b0;
    send(4'd9, 32'h8000_0000, 32'd4, 5'd6, 1'b1);
    held = result;
    checks++; if (held !== 32'hF800_0000) begin failures++; $display("FAIL sra_result got=%h exp=f8000000", held); end
    op = 4'd0; operand_a = 32'd1; operand_b = 32'd2; dest_reg = 5'd7; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0) bad++;
      tick();
      if (out_valid !== 1'b1 || result !== 32'hF800_0000 || dest_reg_out !== 5'd6) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d violations exp=0", bad); end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd3 || dest_reg_out !== 5'd7) begin
      failures++; $display("FAIL stall_release valid=%b got=%h dest=%0d exp=3 dest=7", out_valid, result, dest_reg_out);
    end
    tick();
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b1;
    send(4'd11, 32'd100, 32'd7, 5'd2, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_idle out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_result got=%0d valid cycles exp=0", seen); end
    op = 4'd0; operand_a = 32'd1; operand_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_blocks_accept got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(4'd14, 32'h1234, 32'h5678, 5'd9, 1'b1);
    checks++; if (illegal_op !== 1'b1 || reg_write_out !== 1'b0) begin
      failures++; $display("FAIL illegal_flags got=%b/%b exp=1/0", illegal_op, reg_write_out);
    end
    checks++; if (result !== '0 || zero !== 1'b1) begin failures++; $display("FAIL illegal_result got=%h zero=%b exp=0 zero=1", result, zero); end
    tick();
  endtask

  task automatic test_rst_mid_mul();
    out_ready = 1'b1;
    send(4'd3, 32'h00F0, 32'h000F, 5'd7, 1'b1);
    tick();
    send(4'd10, 32'd1234, 32'd5678, 5'd9, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b0 || illegal_op !== 1'b0 ||
                  dest_reg_out !== '0 || reg_write_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_mul valid=%b res=%h zero=%b ill=%b dest=%0d rw=%b exp all 0",
               out_valid, result, zero, illegal_op, dest_reg_out, reg_write_out);
    end
    for (int i = 0; i < 40; i++) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_abandons_mul got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [3:0] o;
    logic [W-1:0] a, b, e;
    logic [4:0] d;
    logic rw, ill;
    int cycles;
    for (int n = 0; n < 60; n++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      d = 5'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      ill = (o >= 4'd13);
      exp_q.push_back(ref_result(o, a, b));
      exp_dest_q.push_back(d);
      exp_rw_q.push_back(rw && !ill);
      exp_ill_q.push_back(ill);
      out_ready = 1'b0;
      send(o, a, b, d, rw);
      wait_out(60, cycles);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || result !== e || zero !== (e == '0)) begin
        failures++;
        $display("FAIL rand%0d_result op=%0d a=%h b=%h valid=%b got=%h zero=%b exp=%h", n, o, a, b, out_valid, result, zero, e);
      end
      checks++; if (dest_reg_out !== exp_dest_q.pop_front() || reg_write_out !== exp_rw_q.pop_front() ||
                    illegal_op !== exp_ill_q.pop_front()) begin
        failures++;
        $display("FAIL rand%0d_meta op=%0d got dest=%0d rw=%b ill=%b", n, o, dest_reg_out, reg_write_out, illegal_op);
      end
      out_ready = 1'b1;
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_div();
    test_stall();
    test_flush();
    test_illegal();
    test_rst_mid_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
